// File: rtl/div_job_sequencer_if.sv
// div_job_sequencer_if
//   Bundles the three buses of the divider job sequencer.
//   request : req_valid/req_ready handshake with req_aq (dividend),
//             req_div (divisor) and req_tag (opaque job tag)
//   divider : div_start pulse with div_aq/div_div operands out,
//             div_ready pulse with div_quotient/div_remainder back
//   result  : res_valid/res_ready handshake with res_quotient,
//             res_remainder, res_tag and res_err
//   modport slave  : the sequencer's view
//   modport master : the environment's view (requester, divider, consumer)
interface div_job_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [11:0]      req_aq;
  logic [5:0]       req_div;
  logic [TAG_W-1:0] req_tag;

  logic             div_start;
  logic [11:0]      div_aq;
  logic [5:0]       div_div;
  logic             div_ready;
  logic [5:0]       div_quotient;
  logic [5:0]       div_remainder;

  logic             res_valid;
  logic             res_ready;
  logic [5:0]       res_quotient;
  logic [5:0]       res_remainder;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_err;

  modport slave (
    input  req_valid, req_aq, req_div, req_tag,
    input  div_ready, div_quotient, div_remainder,
    input  res_ready,
    output req_ready, div_start, div_aq, div_div,
    output res_valid, res_quotient, res_remainder, res_tag, res_err
  );

  modport master (
    output req_valid, req_aq, req_div, req_tag,
    output div_ready, div_quotient, div_remainder,
    output res_ready,
    input  req_ready, div_start, div_aq, div_div,
    input  res_valid, res_quotient, res_remainder, res_tag, res_err
  );
endinterface

// File: rtl/div_job_sequencer.sv
// div_job_sequencer
//   Front end for the 12-by-6 restoring divider. Buffers jobs in a DEPTH-entry
//   FIFO, rejects divide-by-zero and quotient-overflow jobs without touching
//   the divider, issues the rest with a one-cycle start pulse, and returns
//   results in order with tag and error code.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : request / divider / result buses (slave modport)
//   res_err: 00 ok, 01 divide-by-zero, 10 timeout, 11 quotient overflow
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a queued job; loads and pops the FIFO head
//   CHECK | screens the loaded job for divide-by-zero / overflow
//   START | one-cycle div_start pulse, arms the timeout counter
//   WAIT  | waiting for div_ready or timeout
//   OUT   | result presented until res_ready
module div_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  div_job_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [11:0]      fifo_aq  [DEPTH];
  logic [5:0]       fifo_div [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fifo_full, push, pop;

  logic [11:0]      job_aq_q, job_aq_d;
  logic [5:0]       job_div_q, job_div_d;
  logic [TAG_W-1:0] job_tag_q, job_tag_d;
  logic [5:0]       res_q_q, res_q_d;
  logic [5:0]       res_r_q, res_r_d;
  logic [1:0]       res_err_q, res_err_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign fifo_full = (cnt_q == CNT_W'(DEPTH));
  assign push      = bus.req_valid && !fifo_full;

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_aq[wr_ptr_q]  <= bus.req_aq;
      fifo_div[wr_ptr_q] <= bus.req_div;
      fifo_tag[wr_ptr_q] <= bus.req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      job_aq_q  <= '0;
      job_div_q <= '0;
      job_tag_q <= '0;
      res_q_q   <= '0;
      res_r_q   <= '0;
      res_err_q <= ERR_OK;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      job_aq_q  <= job_aq_d;
      job_div_q <= job_div_d;
      job_tag_q <= job_tag_d;
      res_q_q   <= res_q_d;
      res_r_q   <= res_r_d;
      res_err_q <= res_err_d;
      tmr_q     <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    job_aq_d  = job_aq_q;
    job_div_d = job_div_q;
    job_tag_d = job_tag_q;
    res_q_d   = res_q_q;
    res_r_d   = res_r_q;
    res_err_d = res_err_q;
    tmr_d     = tmr_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          job_aq_d  = fifo_aq[rd_ptr_q];
          job_div_d = fifo_div[rd_ptr_q];
          job_tag_d = fifo_tag[rd_ptr_q];
          pop       = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (job_div_q == '0) begin
          res_q_d   = '0;
          res_r_d   = '0;
          res_err_d = ERR_DIV0;
          state_d   = S_OUT;
        end else if (job_aq_q[11:6] >= job_div_q) begin
          // Quotient would not fit in 6 bits.
          res_q_d   = '0;
          res_r_d   = '0;
          res_err_d = ERR_OVF;
          state_d   = S_OUT;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Down-counter reaches zero on the TIMEOUT-th WAIT cycle.
        tmr_d   = TMR_W'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_ready) begin
          res_q_d   = bus.div_quotient;
          res_r_d   = bus.div_remainder;
          res_err_d = ERR_OK;
          state_d   = S_OUT;
        end else if (tmr_q == '0) begin
          res_q_d   = '0;
          res_r_d   = '0;
          res_err_d = ERR_TMO;
          state_d   = S_OUT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_OUT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready     = !fifo_full;
  assign bus.div_start     = (state_q == S_START);
  assign bus.div_aq        = job_aq_q;
  assign bus.div_div       = job_div_q;
  assign bus.res_valid     = (state_q == S_OUT);
  assign bus.res_quotient  = res_q_q;
  assign bus.res_remainder = res_r_q;
  assign bus.res_tag       = job_tag_q;
  assign bus.res_err       = res_err_q;

endmodule

// File: tb/tb_div_job_sequencer.sv
// tb_div_job_sequencer
//   Bench for div_job_sequencer: a directed vector table, hand-written
//   sequences for back-pressure, timeout and mid-job reset, and a random
//   phase. A divider stub answers start pulses; a monitor compares every
//   result handshake against a queue-based reference model.
module tb_div_job_sequencer;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int NRAND   = 40;

  logic clk = 1'b0;
  logic rst;

  div_job_sequencer_if #(.TAG_W(TAG_W)) bus ();

  div_job_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]      aq;
    logic [5:0]       dv;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef struct {
    int aq; int dv; int tag; int q; int r; int err; int starts;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int n_starts = 0;
  int res_cnt = 0;
  int stray_cnt = 0;
  bit stub_hang = 1'b0;
  bit expect_tmo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: the screening rules and the division, in plain arithmetic.
  function automatic void model(input job_t j, input bit tmo,
                                output int q, output int r, output int e);
    int a, d;
    a = int'(j.aq);
    d = int'(j.dv);
    q = 0; r = 0;
    if (d == 0)             e = 1;
    else if (a / 64 >= d)   e = 3;
    else if (tmo)           e = 2;
    else begin
      e = 0; q = a / d; r = a % d;
    end
  endfunction

  // Divider stub: answers each start pulse after 33..45 cycles, unless hung.
  task automatic stub_loop();
    int cd = 0;
    int stray_done = 0;
    int a, d;
    logic [5:0] q_l = '0, r_l = '0;
    forever begin
      @(posedge clk); #1;
      bus.div_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.div_ready = 1'b1;
          bus.div_quotient = q_l;
          bus.div_remainder = r_l;
        end
      end
      if (stray_cnt != stray_done) begin
        stray_done++;
        bus.div_ready = 1'b1;
        bus.div_quotient = 6'h2a;
        bus.div_remainder = 6'h15;
      end
      if (bus.div_start) begin
        n_starts++;
        if (!stub_hang) begin
          a = int'(bus.div_aq);
          d = int'(bus.div_div);
          if (d != 0) begin
            q_l = 6'(a / d);
            r_l = 6'(a % d);
          end
          cd = $urandom_range(33, 45);
        end
      end
    end
  endtask

  task automatic mon_loop();
    job_t jq[$];
    job_t j;
    int q, r, e;
    bit pv = 0, pr = 0, ps = 0;
    logic [17:0] pdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        jq.delete();
        pv = 0; pr = 0; ps = 0;
        continue;
      end
      if (pv && !pr) begin
        chk("res_hold_valid", bus.res_valid, 1);
        chk("res_hold_data", {bus.res_quotient, bus.res_remainder, bus.res_tag, bus.res_err}, pdata);
      end
      if (bus.div_start) chk("div_start_one_cycle", ps, 0);
      ps = bus.div_start;
      if (bus.res_valid && bus.res_ready) begin
        if (jq.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          j = jq.pop_front();
          model(j, expect_tmo, q, r, e);
          chk("sb_quotient", bus.res_quotient, q);
          chk("sb_remainder", bus.res_remainder, r);
          chk("sb_err", bus.res_err, e);
          chk("sb_tag", bus.res_tag, j.tag);
        end
        res_cnt++;
      end
      if (bus.req_valid && bus.req_ready) jq.push_back({bus.req_aq, bus.req_div, bus.req_tag});
      pv = bus.res_valid;
      pr = bus.res_ready;
      pdata = {bus.res_quotient, bus.res_remainder, bus.res_tag, bus.res_err};
    end
  endtask

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic send_req(input int aq, input int dv, input int tag, input bit keep,
                          input int bound, output bit acc);
    bus.req_valid = 1'b1;
    bus.req_aq = 12'(aq);
    bus.req_div = 6'(dv);
    bus.req_tag = TAG_W'(tag);
    acc = 1'b0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk); #1;
    end
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_res(input int bound, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < bound && !ok) begin
      @(negedge clk);
      cycles++;
      ok = bus.res_valid;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_req_ready"}, bus.req_ready, 1);
    chk({pfx, "_res_zero"}, {bus.res_valid, bus.res_quotient, bus.res_remainder, bus.res_tag, bus.res_err}, 0);
    chk({pfx, "_div_zero"}, {bus.div_start, bus.div_aq, bus.div_div}, 0);
  endtask

  task automatic run_one(input vec_t v);
    bit acc, ok;
    int cyc, s0;
    s0 = n_starts;
    send_req(v.aq, v.dv, v.tag, 1'b0, 20, acc);
    chk("req_accepted", acc, 1);
    wait_res(100, cyc, ok);
    chk("res_arrives", ok, 1);
    if (ok) begin
      if (v.err == 1 || v.err == 3) chk("err_latency_le3", cyc <= 3, 1);
      @(negedge clk);
      chk("res_held_no_ready", bus.res_valid, 1);
      @(posedge clk); #1;
      chk("res_quotient", bus.res_quotient, v.q);
      chk("res_remainder", bus.res_remainder, v.r);
      chk("res_err", bus.res_err, v.err);
      chk("res_tag", bus.res_tag, v.tag);
      chk("div_start_count", n_starts - s0, v.starts);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk("res_valid_drops", bus.res_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic main_seq();
    vec_t vt[9];
    int aq4[6] = '{100, 500, 448, 447, 300, 77};
    int dv4[6] = '{7, 0, 7, 7, 13, 5};
    bit acc, ok, quiet;
    int cyc, s0, r0, base, aq, dv, guard;

    vt[0] = '{100, 7, 3, 14, 2, 0, 1};
    vt[1] = '{500, 0, 5, 0, 0, 1, 0};
    vt[2] = '{448, 7, 9, 0, 0, 3, 0};
    vt[3] = '{447, 7, 10, 63, 6, 0, 1};
    vt[4] = '{4095, 63, 15, 0, 0, 3, 0};
    vt[5] = '{4031, 63, 1, 63, 62, 0, 1};
    vt[6] = '{0, 1, 0, 0, 0, 0, 1};
    vt[7] = '{63, 1, 2, 63, 0, 0, 1};
    vt[8] = '{64, 1, 4, 0, 0, 3, 0};

    repeat (2) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    for (int i = 0; i < 9; i++) run_one(vt[i]);

    // Back-pressure: one job in flight, four queued, sixth refused.
    for (int k = 0; k < 5; k++) begin
      send_req(aq4[k], dv4[k], k + 1, 1'b1, 3, acc);
      chk("fill_accept", acc, 1);
    end
    send_req(aq4[5], dv4[5], 6, 1'b0, 30, acc);
    chk("full_refuses_6th", acc, 0);
    chk("full_req_ready_low", bus.req_ready, 0);
    r0 = res_cnt;
    bus.res_ready = 1'b1;
    guard = 0;
    while (res_cnt < r0 + 5 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.res_ready = 1'b0;
    chk("drain_count", res_cnt - r0, 5);
    repeat (3) begin @(posedge clk); #1; end

    // Timeout with a stray div_ready one cycle after the timeout decision.
    stub_hang = 1'b1;
    expect_tmo = 1'b1;
    send_req(100, 7, 6, 1'b0, 20, acc);
    chk("tmo_accept", acc, 1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.div_start;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("tmo_start_seen", ok, 1);
    cyc = 0;
    for (int i = 1; i <= TIMEOUT + 4 && cyc == 0; i++) begin
      @(negedge clk);
      if (i == TIMEOUT) stray_cnt++;
      if (bus.res_valid) cyc = i;
    end
    chk("tmo_latency", cyc, TIMEOUT + 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("tmo_valid", bus.res_valid, 1);
    chk("tmo_err", bus.res_err, 2);
    chk("tmo_q_r_zero", {bus.res_quotient, bus.res_remainder}, 0);
    chk("tmo_tag", bus.res_tag, 6);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    stub_hang = 1'b0;
    expect_tmo = 1'b0;
    @(posedge clk); #1;
    run_one('{447, 7, 11, 63, 6, 0, 1});

    // Reset while waiting on the divider with two jobs queued.
    send_req(100, 7, 1, 1'b0, 20, acc);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.div_start;
      @(posedge clk); #1;
    end
    chk("rstw_start_seen", ok, 1);
    send_req(200, 9, 2, 1'b0, 5, acc);
    send_req(300, 13, 3, 1'b0, 5, acc);
    repeat (3) begin @(posedge clk); #1; end
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    s0 = n_starts;
    r0 = res_cnt;
    quiet = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.res_valid || bus.div_start) quiet = 1'b0;
    end
    @(posedge clk); #1;
    chk("rst_drops_jobs", quiet, 1);
    chk("rst_no_results", res_cnt - r0, 0);
    chk("rst_no_starts", n_starts - s0, 0);
    run_one('{1000, 20, 7, 50, 0, 0, 1});

    // Random jobs with random result back-pressure.
    base = res_cnt;
    fork
      begin
        for (int k = 0; k < NRAND; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          dv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
          if (dv != 0 && $urandom_range(0, 3) != 0) aq = int'($urandom_range(0, dv * 64 - 1));
          else aq = int'($urandom_range(0, 4095));
          send_req(aq, dv, k, 1'b0, 2000, acc);
          chk("rand_accept", acc, 1);
        end
      end
      begin
        guard = 0;
        while (res_cnt < base + NRAND && guard < 8000) begin
          bus.res_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
          guard++;
        end
        bus.res_ready = 1'b0;
      end
    join
    chk("rand_all_results", res_cnt - base, NRAND);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_aq = '0;
    bus.req_div = '0;
    bus.req_tag = '0;
    bus.res_ready = 1'b0;
    bus.div_ready = 1'b0;
    bus.div_quotient = '0;
    bus.div_remainder = '0;
    fork
      stub_loop();
      mon_loop();
      begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
      end
      main_seq();
    join_any
  end
endmodule
